md_iter_core: RTL and testbench

- Iterative 32-bit multiply/divide engine for the E-stage HI/LO controller.
- The controller acts as initiator: it pulses start with an opcode and operands, then waits on busy/done. This block is the responder.
- Computes mult/multu (shift-add) and div/divu (restoring), one bit per cycle, with a final sign-fixup cycle.
- Replaces behavioural `*`, `/` and `%` with a fixed-latency, synthesizable datapath.

---
 rtl/md_iter_pkg.sv | 29 ++
 rtl/md_iter_core.sv | 143 ++++++++++++++
 tb/tb_md_iter_core.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_iter_pkg.sv
// Shared opcodes, state encodings and iteration count for the iterative multiply/divide engine.
package md_iter_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = $clog2(MD_ITER);

    function automatic logic is_div(input md_op_e o);
        return o[1];
    endfunction

    // Opcodes with bit0 clear (mult, div) operate on two's-complement operands.
    function automatic logic is_signed_op(input logic [1:0] o);
        return ~o[0];
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative 32-bit multiply/divide: shift-add multiply, restoring divide, one bit per cycle,
// followed by a single sign-fixup cycle that publishes hi/lo and pulses done.
module md_iter_core
    import md_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2 = 2 * WIDTH;

    md_state_e           state;
    md_state_e           state_n;
    logic [MD_CNT_W-1:0] cnt;
    md_op_e              op_r;
    logic                sa;
    logic                sb;
    logic [WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]    mq;
    logic [WIDTH-1:0]    a_raw;
    logic [W2-1:0]       acc;

    logic                accept;
    logic                last;
    logic [WIDTH:0]      mul_sum;
    logic [WIDTH:0]      div_sh;
    logic [WIDTH+1:0]    div_trial;
    logic [W2-1:0]       prod_fix;
    logic [WIDTH-1:0]    quo_fix;
    logic [WIDTH-1:0]    rem_fix;
    logic [WIDTH-1:0]    hi_n;
    logic [WIDTH-1:0]    lo_n;

    // |0x80000000| stays 2^31 because the result is read back as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] n;
        n = -v;
        return v[WIDTH-1] ? $unsigned(n) : $unsigned(v);
    endfunction

    assign accept = (state == MD_IDLE) && start;
    assign last   = (cnt == MD_CNT_W'(MD_ITER - 1));

    always_comb begin
        state_n = state;
        unique case (state)
            MD_IDLE: if (start) state_n = MD_RUN;
            MD_RUN:  if (last)  state_n = MD_FIX;
            MD_FIX:  state_n = MD_IDLE;
            default: state_n = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n != MD_IDLE);
            done  <= (state == MD_FIX);
            if (accept)
                cnt <= '0;
            else if (state == MD_RUN)
                cnt <= cnt + MD_CNT_W'(1);
        end
    end

    // One iteration step: mq holds the multiplier (low product bits shift in behind it)
    // or the dividend/quotient; acc[W2-1:WIDTH] is the running high product or remainder.
    always_comb begin
        mul_sum   = {1'b0, acc[W2-1:WIDTH]} + (mq[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        div_sh    = {acc[W2-1:WIDTH], mq[WIDTH-1]};
        div_trial = {1'b0, div_sh} - {2'b00, mcand};
    end

    always_comb begin
        prod_fix = (sa ^ sb) ? -acc : acc;
        quo_fix  = (sa ^ sb) ? -mq : mq;
        rem_fix  = sa ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
        hi_n     = prod_fix[W2-1:WIDTH];
        lo_n     = prod_fix[WIDTH-1:0];
        if (is_div(op_r)) begin
            if (mcand == '0) begin
                hi_n = a_raw;
                lo_n = '1;
            end else begin
                hi_n = rem_fix;
                lo_n = quo_fix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_r  <= MD_MULT;
            sa    <= 1'b0;
            sb    <= 1'b0;
            mcand <= '0;
            mq    <= '0;
            a_raw <= '0;
            acc   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (accept) begin
            // Multiply is commutative, so a sits in mq for both op classes.
            op_r  <= md_op_e'(op);
            sa    <= is_signed_op(op) & a[WIDTH-1];
            sb    <= is_signed_op(op) & b[WIDTH-1];
            mq    <= is_signed_op(op) ? mag(a) : a;
            mcand <= is_signed_op(op) ? mag(b) : b;
            a_raw <= a;
            acc   <= '0;
        end else if (state == MD_RUN) begin
            if (!is_div(op_r)) begin
                acc <= {mul_sum, acc[WIDTH-1:1]};
                mq  <= {acc[0], mq[WIDTH-1:1]};
            end else if (!div_trial[WIDTH+1]) begin
                acc[W2-1:WIDTH] <= div_trial[WIDTH-1:0];
                mq              <= {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc[W2-1:WIDTH] <= div_sh[WIDTH-1:0];
                mq              <= {mq[WIDTH-2:0], 1'b0};
            end
        end else if (state == MD_FIX) begin
            hi <= hi_n;
            lo <= lo_n;
        end
    end

endmodule

// File: tb/tb_md_iter_core.sv
// Randomized and directed checks of md_iter_core against an arithmetic reference model.
module tb_md_iter_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    md_iter_core #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      sq;
        longint      sr;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        r  = 64'h0;
        case (o)
            2'b00: r = sx * sy;
            2'b01: r = ux * uy;
            2'b10: begin
                if (y == 32'h0) r = {x, 32'hFFFF_FFFF};
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (y == 32'h0) r = {x, 32'hFFFF_FFFF};
                else r = {32'(ux % uy), 32'(ux / uy)};
            end
        endcase
        return r;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    // Called #1 after the start edge; dk = edges after that one until done is seen.
    task automatic wait_done(output logic [31:0] h, output logic [31:0] l, output int dk, output int bn);
        h  = 32'h0;
        l  = 32'h0;
        dk = -1;
        bn = 0;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                dk = k;
                h  = hi;
                l  = lo;
                break;
            end
            if (busy) bn++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'h0;
        b     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", done); end
        n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", hi); end
        n_tests++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", lo); end
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] h;
        logic [31:0] l;
    } vec_t;

    task automatic test_directed();
        vec_t        v[9];
        logic [31:0] h;
        logic [31:0] l;
        int          dk;
        int          bn;
        v[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        v[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        v[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        v[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        v[4] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC};
        v[5] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        v[6] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        v[7] = '{2'b10, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFFF};
        v[8] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            issue(v[i].o, v[i].x, v[i].y);
            wait_done(h, l, dk, bn);
            n_tests++; if (h !== v[i].h) begin n_fail++; $display("FAIL dir%0d_hi got=%h exp=%h", i, h, v[i].h); end
            n_tests++; if (l !== v[i].l) begin n_fail++; $display("FAIL dir%0d_lo got=%h exp=%h", i, l, v[i].l); end
            n_tests++; if (dk !== 33) begin n_fail++; $display("FAIL dir%0d_done_latency got=%0d exp=33", i, dk); end
            n_tests++; if (bn !== 33) begin n_fail++; $display("FAIL dir%0d_busy_cycles got=%0d exp=33", i, bn); end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] exp;
        logic [31:0] h;
        logic [31:0] l;
        int          dk;
        int          bn;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: x = 32'h8000_0000;
                2: y = 32'hFFFF_FFFF;
                3: begin x = $urandom_range(0, 50); y = $urandom_range(1, 9); end
                4: y = $urandom_range(1, 300);
                default: ;
            endcase
            exp = ref_md(o, x, y);
            @(posedge clk); #1;
            issue(o, x, y);
            wait_done(h, l, dk, bn);
            n_tests++;
            if ({h, l} !== exp || dk !== 33) begin
                n_fail++;
                $display("FAIL rand%0d op=%0d a=%h b=%h got=%h_%h@%0d exp=%h_%h@33",
                         i, o, x, y, h, l, dk, exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_ignore_restart();
        logic [31:0] h;
        logic [31:0] l;
        int          dk;
        int          bn;
        @(posedge clk); #1;
        issue(2'b01, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd9;
        b     = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(h, l, dk, bn);
        n_tests++; if (h !== 32'h0) begin n_fail++; $display("FAIL ignore_hi got=%h exp=0", h); end
        n_tests++; if (l !== 32'h0000_000F) begin n_fail++; $display("FAIL ignore_lo got=%h exp=0000000f", l); end
        n_tests++; if (dk !== 23) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=23", dk); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e1;
        logic [63:0] e2;
        logic [31:0] x2;
        logic [31:0] y2;
        logic [31:0] h;
        logic [31:0] l;
        int          dk;
        int          bn;
        e1 = ref_md(2'b00, 32'hFFFF_1234, 32'h0000_0BCD);
        x2 = $urandom;
        y2 = $urandom_range(1, 1000);
        e2 = ref_md(2'b11, x2, y2);
        @(posedge clk); #1;
        issue(2'b00, 32'hFFFF_1234, 32'h0000_0BCD);
        wait_done(h, l, dk, bn);
        n_tests++; if ({h, l} !== e1) begin n_fail++; $display("FAIL b2b_first got=%h_%h exp=%h_%h", h, l, e1[63:32], e1[31:0]); end
        issue(2'b11, x2, y2);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy got=%0b exp=1", busy); end
        n_tests++; if ({hi, lo} !== e1) begin n_fail++; $display("FAIL b2b_held got=%h_%h exp=%h_%h", hi, lo, e1[63:32], e1[31:0]); end
        wait_done(h, l, dk, bn);
        n_tests++; if ({h, l} !== e2) begin n_fail++; $display("FAIL b2b_second got=%h_%h exp=%h_%h", h, l, e2[63:32], e2[31:0]); end
        n_tests++; if (dk !== 33) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=33", dk); end
    endtask

    task automatic test_reset_abort();
        int seen;
        @(posedge clk); #1;
        issue(2'b10, 32'd100, 32'd7);
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL abort_hi got=%h exp=0", hi); end
        n_tests++; if (lo !== 32'h0) begin n_fail++; $display("FAIL abort_lo got=%h exp=0", lo); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_restart();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
